// File: rtl/result_row_writer_pkg.sv
// Shared constants and FSM state type for the result row writer.
// Default values here back the top-level parameter defaults.
package result_row_writer_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int PSYS        = 32;
    localparam int FEATURE_LEN = 128;
    localparam int DEPTH       = 1024;

    localparam int ROUND       = FEATURE_LEN / PSYS;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int NROWS_W     = ADDR_W + 1;
    localparam int CHUNK_IDX_W = $clog2(ROUND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int round_of(input int feature_len, input int lanes);
        return feature_len / lanes;
    endfunction

endpackage

// File: rtl/result_row_writer_row_assembler.sv
// Chunk-to-lane placement register for the lower ROUND-1 chunks of a row,
// one bank (single buffer) or two banks (ping-pong) selected by i_bank.
module row_assembler
    import result_row_writer_pkg::*;
#(
    parameter int CHUNK_W = 128,
    parameter int ROUND_N = 4,
    parameter int NBANK   = 1,
    parameter int IDX_W   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic [IDX_W-1:0]                 i_idx,
    input  logic                             i_bank,
    input  logic [CHUNK_W-1:0]               i_chunk,
    output logic [(ROUND_N-1)*CHUNK_W-1:0]   o_row
);

    localparam int LOW_W = (ROUND_N - 1) * CHUNK_W;

    logic [NBANK*LOW_W-1:0] w_banks;
    logic                   w_sel;

    assign w_sel = (NBANK > 1) ? i_bank : 1'b0;

    // The last chunk of a row is never stored; the top merges it straight into the output row.
    generate
        for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [LOW_W-1:0] r_row;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_row <= '0;
                end else if (i_load && ((NBANK == 1) || (w_sel == 1'(gi)))) begin
                    for (int c = 0; c < ROUND_N - 1; c++) begin
                        if (i_idx == IDX_W'(c)) begin
                            r_row[c*CHUNK_W +: CHUNK_W] <= i_chunk;
                        end
                    end
                end
            end

            assign w_banks[gi*LOW_W +: LOW_W] = r_row;
        end

        if (NBANK == 1) begin : g_one
            assign o_row = w_banks;
        end else begin : g_two
            assign o_row = w_sel ? w_banks[LOW_W +: LOW_W] : w_banks[0 +: LOW_W];
        end
    endgenerate

endmodule

// File: rtl/result_row_writer.sv
// Packs psys-lane result chunks into featureLen-wide rows and writes them at
// sequential row addresses. Define RESULT_ROW_WRITER_PINGPONG_EN for ping-pong banks.
module result_row_writer
    import result_row_writer_pkg::*;
#(
    parameter int dataWidth  = DATA_WIDTH,
    parameter int psys       = PSYS,
    parameter int featureLen = FEATURE_LEN,
    parameter int k          = DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           start,
    input  logic [$clog2(k):0]             num_rows,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [psys*dataWidth-1:0]      in_data,
    output logic                           wr_en,
    output logic [$clog2(k)-1:0]           wr_addr,
    output logic [featureLen*dataWidth-1:0] wr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int ROUND_N = round_of(featureLen, psys);
    localparam int CW      = psys * dataWidth;
    localparam int AW      = $clog2(k);
    localparam int NRW     = AW + 1;
    localparam int IDX_W   = $clog2(ROUND_N);

`ifdef RESULT_ROW_WRITER_PINGPONG_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    state_t                 r_state;
    logic [IDX_W-1:0]       r_chunk;
    logic [NRW-1:0]         r_rows;
    logic [NRW-1:0]         r_row_cnt;
    logic [AW-1:0]          r_wr_addr;
    logic                   r_first;
    logic                   r_wr_en;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_bank;
    logic [featureLen*dataWidth-1:0] r_wr_data;

    logic                   w_stall;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_last_chunk;
    logic [(ROUND_N-1)*CW-1:0] w_low_row;

`ifdef RESULT_ROW_WRITER_PINGPONG_EN
    assign w_stall = 1'b0;
`else
    assign w_stall = (r_state == S_WRITE);
`endif

    assign w_ready      = r_busy & enable & ~w_stall;
    assign w_accept     = in_valid & w_ready;
    assign w_last_chunk = (r_chunk == IDX_W'(ROUND_N - 1));

    row_assembler #(
        .CHUNK_W (CW),
        .ROUND_N (ROUND_N),
        .NBANK   (NBANK),
        .IDX_W   (IDX_W)
    ) u_row_assembler (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_idx   (r_chunk),
        .i_bank  (r_bank),
        .i_chunk (in_data),
        .o_row   (w_low_row)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_chunk   <= '0;
            r_rows    <= '0;
            r_row_cnt <= '0;
            r_wr_addr <= '0;
            r_first   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bank    <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_rows    <= num_rows;
                        r_row_cnt <= '0;
                        r_chunk   <= '0;
                        r_wr_addr <= '0;
                        r_first   <= 1'b1;
                        if (num_rows == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        if (w_last_chunk) begin
                            r_chunk   <= '0;
                            r_state   <= S_WRITE;
                            r_wr_en   <= 1'b1;
                            r_wr_data <= {in_data, w_low_row};
                            r_first   <= 1'b0;
                            r_bank    <= (NBANK > 1) ? ~r_bank : 1'b0;
                            // First row of a job lands at 0; later rows advance and wrap at k-1.
                            if (!r_first) begin
                                r_wr_addr <= (r_wr_addr == AW'(k - 1)) ? '0 : r_wr_addr + AW'(1);
                            end
                        end else begin
                            r_chunk <= r_chunk + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_row_cnt <= r_row_cnt + NRW'(1);
                    if (r_row_cnt == r_rows - NRW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_chunk <= '0;
                    end else begin
                        r_state <= S_FILL;
                        if (w_accept) begin
                            r_chunk <= r_chunk + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = w_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: doc/result_row_writer.md
# result_row_writer

Write-side counterpart of the transformation/activation row-buffer read path. Accepts `psys`-lane result chunks through a valid/ready handshake and packs `featureLen/psys` consecutive chunks into one `featureLen`-wide row. Writes each completed row into the feature row buffer at a sequential row address, so the next layer can read it back with the same address and lane slicing.

## Interface
Parameters:
- `dataWidth`, 32, bits per feature element
- `psys`, 32, elements per input chunk (systolic array width)
- `featureLen`, 128, elements per row; must be a multiple of `psys` with `featureLen/psys >= 2`
- `k`, 1024, row buffer depth in rows

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  gates chunk acceptance
- `start`  in  1  one-cycle pulse that begins a job; ignored while `busy`
- `num_rows`  in  `$clog2(k)+1`  rows in the job, sampled on `start`, legal range 0..k
- `in_valid`  in  1  chunk present on `in_data`
- `in_ready`  out  1  block accepts the chunk this cycle
- `in_data`  in  `psys*dataWidth`  result chunk, lane 0 in the LSBs
- `wr_en`  out  1  row write strobe, one cycle per row
- `wr_addr`  out  `$clog2(k)`  row address
- `wr_data`  out  `featureLen*dataWidth`  assembled row
- `busy`  out  1  job in progress
- `done`  out  1  job complete; held until the next accepted `start`

## Operation
- `ROUND = featureLen/psys`. Chunk index `j` (0..ROUND-1) within a row lands in `wr_data[(j+1)*psys*dataWidth-1 : j*psys*dataWidth]`. This matches the reader's slicing.
- A chunk is accepted when `in_valid & in_ready`. `in_ready = busy & enable & ~stall`.
- FSM states and transitions:
  - IDLE → FILL on `start` if `num_rows != 0`.
  - IDLE → DONE on `start` if `num_rows == 0`.
  - FILL → WRITE when chunk ROUND-1 is accepted.
  - WRITE → FILL if rows remain.
  - WRITE → DONE after row `num_rows-1`.
  - DONE → FILL or DONE on `start`, by the same rule as IDLE.
- Chunk counter: increments on each accepted chunk and resets to 0 after chunk ROUND-1.
- Row counter: increments on each `wr_en`. `wr_addr` wraps from k-1 to 0 and restarts at 0 on every accepted `start`.
- `enable` low stops acceptance only. A row already in WRITE is still written.
- `in_valid` with `busy` low is ignored; no state changes.
- `start` while `busy` is ignored. A mid-job `num_rows` change has no effect.
- `rst` asserted mid-job: the partial row is discarded, no `wr_en` is issued, and all outputs return to reset values immediately.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- `busy` rises the cycle after `start`. `in_ready` can be high from that cycle.
- Last chunk of a row accepted at cycle t → `wr_en`=1 at t+1. `wr_addr` and `wr_data` are valid in the same cycle and held until the next write.
- `done` rises and `busy` falls together, the cycle after the final `wr_en`.
- `start` accepted with `num_rows`=0 → `done`=1 the next cycle, with no writes.

## Configuration
- `RESULT_ROW_WRITER_PINGPONG_EN` defined:
  - Two row registers are used alternately.
  - `stall` is always 0, so `in_ready` stays high during WRITE.
  - The first chunk of row r+1 may be accepted in the same cycle row r is written.
  - Sustained rate is one chunk per cycle.
- Undefined:
  - A single row register is used.
  - `stall`=1 in WRITE, so `in_ready`=0 that cycle.
  - Sustained rate is ROUND chunks per ROUND+1 cycles.

## Structure
- Shared package holds:
  - `ROUND` and the address-width constants derived from `featureLen`, `psys` and `k`.
  - The FSM state enum typedef (IDLE, FILL, WRITE, DONE).
- Sub-module `row_assembler`: the chunk-to-lane placement register (one or two banks) with a load strobe, chunk index and bank select.
- FSM and counters live in the top module.

## Test plan
Bench parameters: `dataWidth`=32, `psys`=4, `featureLen`=16 (ROUND=4), `k`=8.
- Reset then idle: `in_valid`=1 with no `start` → `in_ready`=0, `wr_en` never asserts, all outputs 0.
- `start`, `num_rows`=1, chunks with element value = global element index 0..15 → exactly one `wr_en`, `wr_addr`=0, lane i of `wr_data` = i, then `done`=1 and `busy`=0 the next cycle.
- `num_rows`=8 then a second job with `num_rows`=3, `in_valid` held high → second job writes to addresses 0,1,2. Without the macro, `in_ready` has exactly one low cycle per row; with the macro, `in_ready` stays high throughout and 32 chunks are accepted in 32 cycles.
- `enable` low for 5 cycles mid-row (after chunk 2) → no acceptance during the gap, and the row is written intact with chunks in order.
- `start` with `num_rows`=0 → `done`=1 next cycle, no `wr_en`. `start` pulsed again while `busy` → ignored.
- `rst` asserted after 3 of 4 chunks → no `wr_en`. The next job's first row is written at `wr_addr`=0 containing only the new chunks.
